// File: rtl/updown_counter_param.sv
// updown_counter_param: modulo-MOD_VAL up/down counter with a parallel load,
// a registered terminal-count pulse and a saturating wrap-event counter.
// Optional build macro: UPDOWN_COUNTER_SAT_EN. When it is defined, limit
// events hold the count at its end value instead of wrapping around.
// Register priority on each rising clk edge is clr > load > enable.
module updown_counter_param #(
    parameter int              WIDTH   = 8,
    parameter longint unsigned MOD_VAL = 256,
    parameter int              WRAPS_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               enable,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   data,
    output logic               tc,
    output logic [WRAPS_W-1:0] wraps
);

    // Largest legal count value. For MOD_VAL = 2^WIDTH this is all ones,
    // so the explicit limit handling matches natural WIDTH-bit wrap-around.
    localparam logic [WIDTH-1:0]   MAX_VAL   = WIDTH'(MOD_VAL - 64'd1);
    localparam logic [WIDTH-1:0]   ZERO_VAL  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONE_VAL   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WRAPS_W-1:0] WRAPS_MAX = {WRAPS_W{1'b1}};
    localparam logic [WRAPS_W-1:0] WRAPS_ONE = {{(WRAPS_W-1){1'b0}}, 1'b1};

`ifdef UPDOWN_COUNTER_SAT_EN
    // Saturating build: limit events pin the count at the limit just reached.
    localparam logic [WIDTH-1:0]   UP_EVT_VAL   = MAX_VAL;
    localparam logic [WIDTH-1:0]   DOWN_EVT_VAL = ZERO_VAL;
`else
    // Wrapping build: limit events roll over to the opposite end of the range.
    localparam logic [WIDTH-1:0]   UP_EVT_VAL   = ZERO_VAL;
    localparam logic [WIDTH-1:0]   DOWN_EVT_VAL = MAX_VAL;
`endif

    // Out-of-range load values are clamped to the top of the count range so
    // that data can never hold a value at or above MOD_VAL.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v > MAX_VAL) begin
            r = MAX_VAL;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Saturating increment of the wrap-event counter.
    function automatic logic [WRAPS_W-1:0] wraps_inc(input logic [WRAPS_W-1:0] w);
        logic [WRAPS_W-1:0] r;
        if (w == WRAPS_MAX) begin
            r = w;
        end else begin
            r = w + WRAPS_ONE;
        end
        return r;
    endfunction

    logic [WIDTH-1:0]   data_r;
    logic               tc_r;
    logic [WRAPS_W-1:0] wraps_r;

    logic [WIDTH-1:0]   data_nxt_s;
    logic               tc_nxt_s;
    logic [WRAPS_W-1:0] wraps_nxt_s;
    logic               event_s;

    // Next-state logic: load beats counting, and a limit event raises tc and bumps wraps.
    always_comb begin
        data_nxt_s  = data_r;
        tc_nxt_s    = 1'b0;
        wraps_nxt_s = wraps_r;
        event_s     = 1'b0;
        if (load) begin
            data_nxt_s = clamp_load(load_val);
        end else if (enable) begin
            if (up) begin
                if (data_r >= MAX_VAL) begin
                    event_s    = 1'b1;
                    data_nxt_s = UP_EVT_VAL;
                end else begin
                    data_nxt_s = data_r + ONE_VAL;
                end
            end else begin
                if (data_r == ZERO_VAL) begin
                    event_s    = 1'b1;
                    data_nxt_s = DOWN_EVT_VAL;
                end else begin
                    data_nxt_s = data_r - ONE_VAL;
                end
            end
        end else begin
            data_nxt_s = data_r;
        end

        if (event_s) begin
            tc_nxt_s    = 1'b1;
            wraps_nxt_s = wraps_inc(wraps_r);
        end else begin
            tc_nxt_s    = 1'b0;
            wraps_nxt_s = wraps_r;
        end
    end

    // State registers with synchronous clear taking precedence over everything else.
    always_ff @(posedge clk) begin
        if (clr) begin
            data_r  <= ZERO_VAL;
            tc_r    <= 1'b0;
            wraps_r <= {WRAPS_W{1'b0}};
        end else begin
            data_r  <= data_nxt_s;
            tc_r    <= tc_nxt_s;
            wraps_r <= wraps_nxt_s;
        end
    end

    assign data  = data_r;
    assign tc    = tc_r;
    assign wraps = wraps_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed-vector bench for updown_counter_param (WIDTH=4, MOD_VAL=10,
// WRAPS_W=2). Stimulus pushes the hand-computed post-edge expectation into a
// queue; an independent monitor pops and compares one entry after each edge.
module tb_updown_counter_param;

`ifdef UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int         id;
        logic [3:0] d;
        logic       t;
        logic [1:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       enable = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] data;
    logic       tc;
    logic [1:0] wraps;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   miscompares = 0;
    int   issued = 0;

    updown_counter_param #(.WIDTH(4), .MOD_VAL(10), .WRAPS_W(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .enable   (enable),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .data     (data),
        .tc       (tc),
        .wraps    (wraps)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic apply(input logic c, input logic ld, input logic [3:0] lv,
                         input logic en, input logic u,
                         input logic [3:0] ed, input logic et, input logic [1:0] ew);
        exp_t e;
        @(negedge clk);
        clr      = c;
        load     = ld;
        load_val = lv;
        enable   = en;
        up       = u;
        e.id = issued;
        e.d  = ed;
        e.t  = et;
        e.w  = ew;
        exp_q.push_back(e);
        issued++;
    endtask

    // Monitor: after every rising edge, compare the DUT against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vec_cnt++;
                if (data !== e.d || tc !== e.t || wraps !== e.w) begin
                    miscompares++;
                    $display("FAIL vec%0d: got data=%0d tc=%0b wraps=%0d, want data=%0d tc=%0b wraps=%0d",
                             e.id, data, tc, wraps, e.d, e.t, e.w);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", exp_q.size());
        $fatal(1, "timeout");
    end

    // Directed stimulus sequence.
    initial begin
        logic [3:0] d;
        logic       t;
        logic [1:0] w;

        // reset state
        apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0);
        // down-event from 0: wrap to 9 or hold 0, tc and wraps=1
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, SAT ? 4'd0 : 4'd9, 1'b1, 2'd1);
        // idle: tc drops, state holds
        apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, SAT ? 4'd0 : 4'd9, 1'b0, 2'd1);
        // clr overrides load and enable
        apply(1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0);
        // load of out-of-range 15 clamps to 9, no tc
        apply(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'd9, 1'b0, 2'd0);
        // up-event from 9
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, SAT ? 4'd9 : 4'd0, 1'b1, 2'd1);
        // load 5, wraps untouched
        apply(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 2'd1);
        // clr + load + enable with data=5
        apply(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0);
        // load 7 then ten idle cycles with a different load_val present
        apply(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 2'd0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 4'd7, 1'b0, 2'd0);
        end
        // load boundaries and load beating enable at both limits
        apply(1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 4'd9, 1'b0, 2'd0);
        apply(1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 4'd9, 1'b0, 2'd0);
        apply(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0);
        apply(1'b0, 1'b1, 4'd4, 1'b1, 1'b1, 4'd4, 1'b0, 2'd0);

        // 50 consecutive up cycles from 0: five events, wraps saturates at 3
        apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0);
        for (int i = 1; i <= 50; i++) begin
            if (SAT) begin
                d = (i < 9) ? 4'(i) : 4'd9;
                t = (i >= 10);
                w = (i < 10) ? 2'd0 : ((i - 9) >= 3 ? 2'd3 : 2'(i - 9));
            end else begin
                d = 4'(i % 10);
                t = ((i % 10) == 0);
                w = ((i / 10) >= 3) ? 2'd3 : 2'(i / 10);
            end
            apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, d, t, w);
        end

        // clr mid-count aborts; next count starts from 0
        apply(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 2'd0);

        // direction changes take effect on the same edge
        apply(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 2'd0);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, SAT ? 4'd0 : 4'd9, 1'b1, 2'd1);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, SAT ? 4'd1 : 4'd0, SAT ? 1'b0 : 1'b1, SAT ? 2'd1 : 2'd2);
        apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, SAT ? 4'd0 : 4'd9, SAT ? 1'b0 : 1'b1, SAT ? 2'd1 : 2'd3);

        // release inputs and let the monitor drain the queue
        @(negedge clk);
        clr = 1'b0; load = 1'b0; enable = 1'b0; up = 1'b0; load_val = 4'd0;
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
UPDOWN_COUNTER_PARAM -- requirements
Module: updown_counter_param

Interface
REQ-001 Parameter WIDTH, default 8, count register width in bits (legal range 2..32).
REQ-002 Parameter MOD_VAL, default 256, count modulus; count range is 0..MOD_VAL-1; legal range 2..2^WIDTH.
REQ-003 Parameter WRAPS_W, default 8, width of the wrap-event counter.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 clr  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  count-enable qualifier.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous parallel-load strobe.
REQ-009 load_val  input  WIDTH  value for parallel load.
REQ-010 data  output  WIDTH  current count, registered.
REQ-011 tc  output  1  terminal-count pulse, registered, one cycle per wrap/limit event.
REQ-012 wraps  output  WRAPS_W  number of wrap/limit events since reset, registered.

Function
REQ-013 Priority per rising edge SHALL be clr > load > enable; with none asserted, all registers hold.
REQ-014 load SHALL set data to load_val if load_val <= MOD_VAL-1, else to MOD_VAL-1; load SHALL NOT assert tc or change wraps.
REQ-015 enable=1, up=1, data < MOD_VAL-1: data SHALL become data+1 next cycle.
REQ-016 enable=1, up=0, data > 0: data SHALL become data-1 next cycle.
REQ-017 Up-event: enable=1, up=1, data = MOD_VAL-1; down-event: enable=1, up=0, data = 0.
REQ-018 On an up-event data SHALL become 0; on a down-event data SHALL become MOD_VAL-1 (wrap mode, see REQ-026).
REQ-019 tc SHALL be 1 in the cycle following an up- or down-event and 0 otherwise; latency exactly one clock.
REQ-020 wraps SHALL increment by 1 on each up- or down-event and saturate at 2^WRAPS_W-1.
REQ-021 up changing while enable=1 SHALL take effect on the same edge; no turnaround cycle.
REQ-022 All arithmetic SHALL be performed modulo MOD_VAL; data SHALL never hold a value >= MOD_VAL.
REQ-023 For MOD_VAL = 2^WIDTH the behaviour SHALL equal natural WIDTH-bit wrap-around.

Reset
REQ-024 clr=1 on a rising edge SHALL set data=0, tc=0, wraps=0, overriding load and enable in the same cycle.
REQ-025 clr asserted mid-count SHALL abort the count; first count after clr deasserts starts from 0.

Configuration
REQ-026 Macro UPDOWN_COUNTER_SAT_EN: when defined, an up-event SHALL hold data at MOD_VAL-1 and a down-event SHALL hold data at 0 (saturation), still asserting tc and incrementing wraps on each such event; when undefined, wrap behaviour of REQ-018 SHALL apply.

Verification
REQ-027 WIDTH=8, MOD_VAL=256: clr, then enable=1, up=1 for 256 cycles -> data 0..255 then 0; tc=1 exactly one cycle after the 255->0 edge; wraps=1.
REQ-028 MOD_VAL=10: from clr, enable=1, up=0 one cycle -> data=9, tc=1 next cycle, wraps=1; with UPDOWN_COUNTER_SAT_EN data stays 0, tc=1, wraps=1.
REQ-029 MOD_VAL=10: load=1, load_val=15 -> data=9, tc=0; then enable=1, up=1 -> data=0 (wrap) or 9 (saturate), tc=1.
REQ-030 clr=1, load=1, enable=1 same cycle with data=5 -> data=0, tc=0, wraps=0.
REQ-031 WRAPS_W=2, MOD_VAL=4: 20 consecutive up cycles -> 5 events, wraps saturates at 3, tc pulses 5 times.
REQ-032 enable=0, load=0 for 10 cycles with data=7 -> data holds 7, tc=0, wraps unchanged.
